// File: rtl/arbiter_if.sv
// Request/grant bundle shared between the round-robin arbiter and its requesters.
// Bit index i of request and grant always refers to port i.
interface arbiter_if #(
    parameter int NUM_PORTS = 9
);
    logic [0:NUM_PORTS-1] request;
    logic [0:NUM_PORTS-1] grant;
    logic                 active;

    modport master (
        output request,
        input  grant,
        input  active
    );

    modport slave (
        input  request,
        output grant,
        output active
    );
endinterface

// File: rtl/arbiter.sv
// Locking round-robin arbiter: a grant is held while its request stays high,
// then passes to the next requester in cyclic order after the last winner.
module arbiter #(
    parameter int NUM_PORTS = 9
) (
    input  logic     clk,
    input  logic     rst,
    arbiter_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [0:NUM_PORTS-1] grant_q;
    logic [0:NUM_PORTS-1] grant_d;
    logic [PW-1:0]        last_q;
    logic [PW-1:0]        last_d;
    logic                 first_q;
    logic                 active_q;
    logic                 hold;
    logic                 found;
    logic [PW:0]          idx;
    logic [PW:0]          start_off;

    // Grant is one-hot, so the holder still requests iff any overlap remains.
    assign hold = |(grant_q & bus.request);

    // Until the first grant after reset, port 0 itself is searched first.
    assign start_off = first_q ? '0 : (PW + 1)'(1);

    always_comb begin
        grant_d = '0;
        last_d  = last_q;
        found   = 1'b0;
        idx     = '0;
        if (hold) begin
            grant_d = grant_q;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = {1'b0, last_q} + (PW + 1)'(k) + start_off;
                if (idx >= (PW + 1)'(NUM_PORTS)) begin
                    idx = idx - (PW + 1)'(NUM_PORTS);
                end
                if (!found && bus.request[idx[PW-1:0]]) begin
                    found                = 1'b1;
                    grant_d[idx[PW-1:0]] = 1'b1;
                    last_d               = idx[PW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= '0;
            active_q <= 1'b0;
            last_q   <= '0;
            first_q  <= 1'b1;
        end else begin
            grant_q  <= grant_d;
            active_q <= |grant_d;
            last_q   <= last_d;
            if (found) begin
                first_q <= 1'b0;
            end
        end
    end

    assign bus.grant  = grant_q;
    assign bus.active = active_q;
endmodule

// File: tb/tb_arbiter.sv
// Directed scoreboard bench for the 9-port locking round-robin arbiter.
// Stimulus pushes the hand-computed grant for each edge; the monitor pops and compares.
module tb_arbiter;
    localparam int N = 9;

    typedef struct {
        logic [0:N-1] grant;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks;
    int   failures;

    arbiter_if #(.NUM_PORTS(N)) bus ();

    arbiter #(.NUM_PORTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic [0:N-1] req,
                                 input logic [0:N-1] exp_grant, input string tag);
        @(negedge clk);
        rst         = r;
        bus.request = req;
        sb.push_back('{exp_grant, tag});
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.grant !== e.grant) begin
            failures++;
            $display("[TB] FAIL grant %s: got %b expected %b", e.tag, bus.grant, e.grant);
        end
        checks++;
        if (bus.active !== (|e.grant)) begin
            failures++;
            $display("[TB] FAIL active %s: got %b expected %b", e.tag, bus.active, |e.grant);
        end
        checks++;
        if ($countones(bus.grant) > 1) begin
            failures++;
            $display("[TB] FAIL onehot %s: got %b expected at most one bit set", e.tag, bus.grant);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [0:N-1] req;
        logic [0:N-1] exp_g;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.request = '0;

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 9'b000000000, 9'b000000000, "reset");
        for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 9'b000000000, 9'b000000000, "post_reset_idle");

        // Ports 0 and 8 both request; port 0 wins first after reset and locks.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 9'b100000001, 9'b100000000, "initial_priority");

        applyStimulus(1'b0, 9'b000000010, 9'b000000010, "handover_port7");
        applyStimulus(1'b0, 9'b010000001, 9'b000000001, "next_after_7_is_8");
        applyStimulus(1'b0, 9'b000000001, 9'b000000001, "hold_port8");
        applyStimulus(1'b0, 9'b010000001, 9'b000000001, "hold_port8_with_other");

        applyStimulus(1'b0, 9'b010000000, 9'b010000000, "wrap_to_port1");
        applyStimulus(1'b0, 9'b000100000, 9'b000100000, "port3");

        applyStimulus(1'b0, 9'b000000000, 9'b000000000, "idle");
        applyStimulus(1'b0, 9'b000100000, 9'b000100000, "regrant_port3");

        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 9'b111111111, 9'b000100000, "all_ones_lock");

        // Drop the holder's bit each cycle; grant walks 4,5,6,7,8, wraps to 0,1,2.
        req = 9'b111011111;
        for (int p = 4; p < 12; p++) begin
            exp_g = '0;
            exp_g[p % N] = 1'b1;
            applyStimulus(1'b0, req, exp_g, $sformatf("rotate_port%0d", p % N));
            req[p % N] = 1'b0;
        end
        applyStimulus(1'b0, req, 9'b000000000, "rotate_drained");

        // Pointer is at 2, so port 0 is reached only after 3..8; then reset mid-grant.
        applyStimulus(1'b0, 9'b100000000, 9'b100000000, "grant_port0");
        applyStimulus(1'b1, 9'b100000000, 9'b000000000, "reset_mid_grant");
        applyStimulus(1'b0, 9'b100000001, 9'b100000000, "pointer_back_to_0");
        applyStimulus(1'b0, 9'b000000001, 9'b000000001, "handover_port8");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/arbiter.md
Name: arbiter

Overview:
Parameterised, locking round-robin arbiter: one registered one-hot grant among NUM_PORTS requesters. A grant is held for as long as the granted port keeps its request asserted. On release, the next grant goes to the next requesting port in cyclic order after the last winner. Used wherever several masters share one resource (bus, memory port, FIFO write side).

Parameters:
NUM_PORTS, 9, number of requester ports (≥2); sets width of request/grant.

Ports:
clk  input  1  rising-edge clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
request  input  [0:NUM_PORTS-1]  per-port request; bit index i = port i (port 0 is the MSB of the written literal)
grant  output  [0:NUM_PORTS-1]  registered one-hot (or all-zero) grant, same bit ordering as request
active  output  1  registered; high when any grant bit is set

Behaviour:
- One clock domain, one synchronous active-high reset (rst sampled on posedge clk).
- Reset: grant = 0, active = 0, round-robin pointer = port 0 (port 0 highest priority). rst dominates all other inputs.
- Internal state:
  - grant register.
  - last-winner pointer (index, width clog2(NUM_PORTS)) or equivalent priority mask.
- Each posedge (rst low), next grant is computed from the current request and state:
  - Hold: current grant g is nonzero and request[g] = 1 -> grant unchanged. Other requests are ignored, including all-ones.
  - Re-arbitrate: grant is zero, or request[g] = 0 -> search ports last+1, last+2, … cyclically (wrap NUM_PORTS-1 -> 0), ending at last itself. The first port with its request set wins; grant becomes one-hot at that port and the pointer updates to it.
  - No requests -> grant = 0; pointer keeps its value.
- Handover needs no idle cycle: a released grant moves straight to the next requester on the same edge that sees the request drop.
- Latency: request rising at edge n-1 (set up before edge n) -> grant visible after edge n (one cycle, registered). A released request -> grant drops or changes after the next edge.
- active = |grant, registered together with grant (identical timing; never high while grant = 0).
- Before the first grant after reset, the pointer sits at port 0 but port 0 has top priority. The search then starts at port 0, not port 1.
- Invariant: grant is always one-hot or zero; never X after reset.
- Reset mid-grant: next edge clears grant and active and returns the pointer to port 0.
- Starvation bound: a requester is served after at most NUM_PORTS-1 other grants, provided holders eventually release.

Test Plan:
- Reset: rst high 10 cycles with request=0 -> grant=000000000, active=0 throughout; after rst low with request=0, outputs stay 0.
- Initial priority: request=100000001 (ports 0,8) -> one cycle later grant=100000000, active=1; held stable for 15 cycles.
- Release/handover: request=000000010 -> grant=000000010 next cycle. Then request=010000001 -> grant=000000001 (port 8 is next after 7). Then request=000000001 followed by 010000001 -> grant stays 000000001.
- Wrap-around: from grant port 8, request=010000000 -> grant=010000000 (wraps to port 1). Then request=000100000 -> grant=000100000.
- Idle and re-grant: request=000000000 for 1 cycle -> grant=0, active=0. Then request=000100000 -> grant=000100000, active=1.
- All-request lock and rotation: request=111111111 while port 3 holds -> grant stays 000100000 for 15 cycles. Then drop bit 3 (111011111) -> grant=000010000 (port 4). Drop bit 4 -> port 5, etc.; verify one-hot grant every cycle.
